// File: rtl/spike_rate_if.sv
// spike_rate_if: groups the run control, spike input and both result
// channels of spike_rate_decoder.
//   master: producer of the spike train / consumer of results
//           (drives ena, spike_in, window_len, rate_ready)
//   slave : the decoder (drives rate_out/valid/sat/overrun, isi_out/valid)
interface spike_rate_if #(
  parameter int WINDOW_W = 8,
  parameter int COUNT_W  = 8,
  parameter int ISI_W    = 8
) ();
  logic                ena;
  logic                spike_in;
  logic [WINDOW_W-1:0] window_len;
  logic [COUNT_W-1:0]  rate_out;
  logic                rate_valid;
  logic                rate_ready;
  logic                rate_sat;
  logic                rate_overrun;
  logic [ISI_W-1:0]    isi_out;
  logic                isi_valid;

  modport master (
    output ena, spike_in, window_len, rate_ready,
    input  rate_out, rate_valid, rate_sat, rate_overrun, isi_out, isi_valid
  );

  modport slave (
    input  ena, spike_in, window_len, rate_ready,
    output rate_out, rate_valid, rate_sat, rate_overrun, isi_out, isi_valid
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: readout stage turning a binary spike train into
// numbers. Counts spikes over back-to-back windows of L cycles
// (window_len, 0 meaning 2^WINDOW_W) and offers each count on a
// valid/ready channel; also measures inter-spike intervals.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - spike_rate_if.slave: ena, spike_in, window_len, rate_ready in;
//           rate_out, rate_valid, rate_sat, rate_overrun, isi_out,
//           isi_valid out (all outputs registered)
module spike_rate_decoder #(
  parameter int WINDOW_W = 8,
  parameter int COUNT_W  = 8,
  parameter int ISI_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  spike_rate_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ISI_W-1:0]   ISI_MAX  = '1;
  localparam logic [WINDOW_W:0]  LEN_FULL = {1'b1, {WINDOW_W{1'b0}}};

  state_e              state_q, state_d;
  logic [WINDOW_W-1:0] cyc_q, cyc_d;
  logic [WINDOW_W:0]   len_q, len_d;       // one extra bit so 2^WINDOW_W fits
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic [ISI_W-1:0]    isi_cnt_q, isi_cnt_d;
  logic                have_prev_q, have_prev_d;
  logic [COUNT_W-1:0]  rate_out_q, rate_out_d;
  logic                rate_valid_q, rate_valid_d;
  logic                rate_sat_q, rate_sat_d;
  logic                rate_overrun_q, rate_overrun_d;
  logic [ISI_W-1:0]    isi_out_q, isi_out_d;
  logic                isi_valid_q, isi_valid_d;

  logic                accept;
  logic                last_edge;
  logic                cnt_full;
  logic [COUNT_W-1:0]  cnt_inc;
  logic                sat_inc;
  logic [ISI_W-1:0]    isi_inc;
  logic [WINDOW_W:0]   len_new;

  always_comb begin
    // NOTE: every variable assigned in this block gets a default first so
    // no path can leave one unassigned and infer a latch.
    state_d        = state_q;
    cyc_d          = cyc_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    sat_d          = sat_q;
    isi_cnt_d      = isi_cnt_q;
    have_prev_d    = have_prev_q;
    rate_out_d     = rate_out_q;
    rate_valid_d   = rate_valid_q;
    rate_sat_d     = rate_sat_q;
    rate_overrun_d = rate_overrun_q;
    isi_out_d      = isi_out_q;
    isi_valid_d    = 1'b0;

    accept    = rate_valid_q & bus.rate_ready;
    len_new   = (bus.window_len == '0) ? LEN_FULL : {1'b0, bus.window_len};
    last_edge = ({1'b0, cyc_q} == (len_q - (WINDOW_W+1)'(1)));
    cnt_full  = (cnt_q == CNT_MAX);
    cnt_inc   = (bus.spike_in && !cnt_full) ? cnt_q + COUNT_W'(1) : cnt_q;
    sat_inc   = sat_q | (bus.spike_in & cnt_full);
    // min(isi_cnt+1, max): serves both the running count and the result
    isi_inc   = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + ISI_W'(1);

    // Handshake runs in either state; a result load below overrides it.
    if (accept) begin
      rate_valid_d   = 1'b0;
      rate_sat_d     = 1'b0;
      rate_overrun_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.ena) begin
          // Start edge: spike_in is deliberately not counted here.
          state_d   = RUN;
          cyc_d     = '0;
          cnt_d     = '0;
          sat_d     = 1'b0;
          isi_cnt_d = '0;
          len_d     = len_new;
        end
      end
      RUN: begin
        if (!bus.ena) begin
          // Abort: partial window dropped, pending result untouched.
          state_d     = IDLE;
          have_prev_d = 1'b0;
        end else begin
          if (last_edge) begin
            rate_out_d     = cnt_inc;
            rate_sat_d     = sat_inc;
            rate_valid_d   = 1'b1;
            rate_overrun_d = rate_valid_q & ~bus.rate_ready;
            cyc_d          = '0;
            cnt_d          = '0;
            sat_d          = 1'b0;
            len_d          = len_new;
          end else begin
            cyc_d = cyc_q + WINDOW_W'(1);
            cnt_d = cnt_inc;
            sat_d = sat_inc;
          end

          if (bus.spike_in) begin
            if (have_prev_q) begin
              isi_out_d   = isi_inc;
              isi_valid_d = 1'b1;
            end
            isi_cnt_d   = '0;
            have_prev_d = 1'b1;
          end else begin
            isi_cnt_d = isi_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cyc_q          <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      sat_q          <= 1'b0;
      isi_cnt_q      <= '0;
      have_prev_q    <= 1'b0;
      rate_out_q     <= '0;
      rate_valid_q   <= 1'b0;
      rate_sat_q     <= 1'b0;
      rate_overrun_q <= 1'b0;
      isi_out_q      <= '0;
      isi_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      sat_q          <= sat_d;
      isi_cnt_q      <= isi_cnt_d;
      have_prev_q    <= have_prev_d;
      rate_out_q     <= rate_out_d;
      rate_valid_q   <= rate_valid_d;
      rate_sat_q     <= rate_sat_d;
      rate_overrun_q <= rate_overrun_d;
      isi_out_q      <= isi_out_d;
      isi_valid_q    <= isi_valid_d;
    end
  end

  assign bus.rate_out     = rate_out_q;
  assign bus.rate_valid   = rate_valid_q;
  assign bus.rate_sat     = rate_sat_q;
  assign bus.rate_overrun = rate_overrun_q;
  assign bus.isi_out      = isi_out_q;
  assign bus.isi_valid    = isi_valid_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder. Inputs are driven on the falling edge,
// outputs are sampled on the following falling edge, i.e. after exactly
// one rising edge has been applied.
module tb_spike_rate_decoder;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  spike_rate_if bus ();

  spike_rate_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ena;
    int spike;
    int rdy;
    int v;
    int rate;
    int sat;
    int ovr;
    int iv;
    int isi;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic s, input int wl, input logic r);
    bus.ena        = e;
    bus.spike_in   = s;
    bus.window_len = 8'(wl);
    bus.rate_ready = r;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rate_out"},     int'(bus.rate_out), 0);
    check({tag, " rate_valid"},   int'(bus.rate_valid), 0);
    check({tag, " rate_sat"},     int'(bus.rate_sat), 0);
    check({tag, " rate_overrun"}, int'(bus.rate_overrun), 0);
    check({tag, " isi_out"},      int'(bus.isi_out), 0);
    check({tag, " isi_valid"},    int'(bus.isi_valid), 0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_vec(input int i, input int e, input int s, input int r,
                         input int v, input int rate, input int sat,
                         input int ovr, input int iv, input int isi);
    vecs[i] = '{e, s, r, v, rate, sat, ovr, iv, isi};
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0);

    // window_len=4: counts 2 then 3 with no consumer (overrun), a one-cycle
    // ready pulse, ready landing on a load edge, ISI pulses incl. back-to-back.
    //          e  s  r  v  rate sat ovr iv isi
    set_vec( 0, 1, 0, 0, 0, 0,   0,  0,  0, 0);
    set_vec( 1, 1, 1, 0, 0, 0,   0,  0,  0, 0);
    set_vec( 2, 1, 1, 0, 0, 0,   0,  0,  1, 1);
    set_vec( 3, 1, 0, 0, 0, 0,   0,  0,  0, 1);
    set_vec( 4, 1, 0, 0, 1, 2,   0,  0,  0, 1);
    set_vec( 5, 1, 1, 0, 1, 2,   0,  0,  1, 3);
    set_vec( 6, 1, 1, 0, 1, 2,   0,  0,  1, 1);
    set_vec( 7, 1, 1, 0, 1, 2,   0,  0,  1, 1);
    set_vec( 8, 1, 0, 0, 1, 3,   0,  1,  0, 1);
    set_vec( 9, 1, 0, 1, 0, 3,   0,  0,  0, 1);
    set_vec(10, 1, 0, 0, 0, 3,   0,  0,  0, 1);
    set_vec(11, 1, 0, 0, 0, 3,   0,  0,  0, 1);
    set_vec(12, 1, 1, 0, 1, 1,   0,  0,  1, 5);
    set_vec(13, 1, 1, 0, 1, 1,   0,  0,  1, 1);
    set_vec(14, 1, 0, 0, 1, 1,   0,  0,  0, 1);
    set_vec(15, 1, 1, 0, 1, 1,   0,  0,  1, 2);
    set_vec(16, 1, 0, 1, 1, 2,   0,  0,  0, 2);
    set_vec(17, 0, 0, 1, 0, 2,   0,  0,  0, 2);

    // Reset state
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Table-driven sequence
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].ena != 0, vecs[i].spike != 0, 4, vecs[i].rdy != 0);
      tick();
      check($sformatf("vec%0d rate_valid", i),   int'(bus.rate_valid),   vecs[i].v);
      check($sformatf("vec%0d rate_out", i),     int'(bus.rate_out),     vecs[i].rate);
      check($sformatf("vec%0d rate_sat", i),     int'(bus.rate_sat),     vecs[i].sat);
      check($sformatf("vec%0d rate_overrun", i), int'(bus.rate_overrun), vecs[i].ovr);
      check($sformatf("vec%0d isi_valid", i),    int'(bus.isi_valid),    vecs[i].iv);
      check($sformatf("vec%0d isi_out", i),      int'(bus.isi_out),      vecs[i].isi);
    end

    // window_len=10, alternating spikes from RUN edge 1, ready held high.
    // window_len switches to 4 mid-window 2: window 2 still runs 10 edges,
    // window 3 runs 4. A spike on the start edge must not be counted.
    do_reset();
    drive(1'b1, 1'b1, 10, 1'b1);
    tick();
    for (int k = 1; k <= 24; k++) begin
      drive(1'b1, (k % 2) == 1, (k >= 15) ? 4 : 10, 1'b1);
      tick();
      check($sformatf("alt k%0d rate_valid", k), int'(bus.rate_valid),
            (k == 10 || k == 20 || k == 24) ? 1 : 0);
      if (k == 10 || k == 20)
        check($sformatf("alt k%0d rate_out", k), int'(bus.rate_out), 5);
      if (k == 24)
        check("alt k24 rate_out", int'(bus.rate_out), 2);
      check($sformatf("alt k%0d rate_sat", k), int'(bus.rate_sat), 0);
      check($sformatf("alt k%0d isi_valid", k), int'(bus.isi_valid),
            ((k % 2) == 1 && k > 1) ? 1 : 0);
      if (k >= 3)
        check($sformatf("alt k%0d isi_out", k), int'(bus.isi_out), 2);
    end

    // window_len=0 (256 cycles) with spike held: count saturates at 255.
    do_reset();
    drive(1'b1, 1'b0, 0, 1'b1);
    tick();
    for (int k = 1; k <= 256; k++) begin
      drive(1'b1, 1'b1, 0, 1'b1);
      tick();
      if (k == 255) check("sat k255 rate_valid", int'(bus.rate_valid), 0);
    end
    check("sat rate_valid", int'(bus.rate_valid), 1);
    check("sat rate_out",   int'(bus.rate_out), 255);
    check("sat rate_sat",   int'(bus.rate_sat), 1);
    check("sat isi_out",    int'(bus.isi_out), 1);
    // ISI counter saturation: 301 silent edges then a spike.
    for (int k = 1; k <= 301; k++) begin
      drive(1'b1, 1'b0, 0, 1'b1);
      tick();
      if (k == 1) begin
        check("sat accept rate_valid", int'(bus.rate_valid), 0);
        check("sat accept rate_sat",   int'(bus.rate_sat), 0);
      end
    end
    drive(1'b1, 1'b1, 0, 1'b1);
    tick();
    check("isi sat isi_valid", int'(bus.isi_valid), 1);
    check("isi sat isi_out",   int'(bus.isi_out), 255);

    // Abort at cyc 5 of 10, then a full fresh window.
    do_reset();
    drive(1'b1, 1'b1, 10, 1'b1);
    tick();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b1, 10, 1'b1);
      tick();
    end
    drive(1'b0, 1'b1, 10, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort idle%0d rate_valid", k), int'(bus.rate_valid), 0);
    end
    drive(1'b1, 1'b1, 10, 1'b1);
    tick();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 1'b1, 10, 1'b1);
      tick();
      check($sformatf("abort k%0d rate_valid", k), int'(bus.rate_valid), (k == 10) ? 1 : 0);
      if (k == 1) check("abort first spike isi_valid", int'(bus.isi_valid), 0);
      if (k == 2) check("abort second spike isi_valid", int'(bus.isi_valid), 1);
    end
    check("abort rate_out", int'(bus.rate_out), 10);
    check("abort rate_overrun", int'(bus.rate_overrun), 0);

    // Asynchronous reset mid-window with a pending result.
    do_reset();
    drive(1'b1, 1'b1, 2, 1'b0);
    tick();
    tick();
    tick();
    check("pre-rst rate_valid", int'(bus.rate_valid), 1);
    check("pre-rst rate_out",   int'(bus.rate_out), 2);
    check("pre-rst isi_valid",  int'(bus.isi_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post-rst idle%0d rate_valid", k), int'(bus.rate_valid), 0);
    end
    drive(1'b1, 1'b1, 2, 1'b0);
    tick();
    tick();
    tick();
    check("post-rst rate_valid", int'(bus.rate_valid), 1);
    check("post-rst rate_out",   int'(bus.rate_out), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
